// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM stage that passes non-memory ops straight through and runs loads/stores
// as byte-serial req/ack transfers, stalling the pipeline until the last byte completes.
module mem_access_unit #(
  parameter int ALUOP_W = 8,
  parameter logic [ALUOP_W-1:0] OP_LB  = 8'h20,
  parameter logic [ALUOP_W-1:0] OP_LH  = 8'h21,
  parameter logic [ALUOP_W-1:0] OP_LW  = 8'h22,
  parameter logic [ALUOP_W-1:0] OP_LBU = 8'h23,
  parameter logic [ALUOP_W-1:0] OP_LHU = 8'h24,
  parameter logic [ALUOP_W-1:0] OP_SB  = 8'h28,
  parameter logic [ALUOP_W-1:0] OP_SH  = 8'h29,
  parameter logic [ALUOP_W-1:0] OP_SW  = 8'h2A
) (
  input  logic               dclk,
  input  logic               rst,
  input  logic [ALUOP_W-1:0] aluop_MEM_i,
  input  logic               wreg_MEM_i,
  input  logic [4:0]         waddr_MEM_i,
  input  logic [31:0]        alurslt_MEM_i,
  input  logic [31:0]        storedata_MEM_i,
  output logic               mem_req_o,
  output logic               mem_we_o,
  output logic [31:0]        mem_addr_o,
  output logic [7:0]         mem_wdata_o,
  input  logic [7:0]         mem_rdata_i,
  input  logic               mem_ack_i,
  output logic               stlreq_MEM_o,
  output logic               wreg_WB_o,
  output logic [4:0]         waddr_WB_o,
  output logic [31:0]        wdata_WB_o
);
  typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;
  state_t state, state_n;
  logic [1:0] cnt, last;
  logic [31:0] data, ext;
  logic is_load, is_store, is_mem, is_b, is_h, pass, wb_load, acked;
  always_comb begin
    is_load  = aluop_MEM_i inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};
    is_store = aluop_MEM_i inside {OP_SB, OP_SH, OP_SW};
    is_mem   = is_load || is_store;
    is_b     = aluop_MEM_i inside {OP_LB, OP_LBU, OP_SB};
    is_h     = aluop_MEM_i inside {OP_LH, OP_LHU, OP_SH};
    last     = is_b ? 2'd0 : is_h ? 2'd1 : 2'd3;
    acked    = (state == XFER) && mem_req_o && mem_ack_i;
    state_n  = (state == IDLE) ? (is_mem ? XFER : IDLE) :
               (state == XFER) ? ((acked && cnt == last) ? DONE : XFER) : IDLE;
    ext      = (aluop_MEM_i == OP_LB)  ? {{24{data[7]}}, data[7:0]} :
               (aluop_MEM_i == OP_LBU) ? {24'd0, data[7:0]} :
               (aluop_MEM_i == OP_LH)  ? {{16{data[15]}}, data[15:0]} :
               (aluop_MEM_i == OP_LHU) ? {16'd0, data[15:0]} : data;
    pass         = (state == IDLE) && !is_mem;
    wb_load      = (state == DONE) && is_load;
    stlreq_MEM_o = ((state == IDLE) && is_mem) || (state == XFER);
    wreg_WB_o    = (pass || wb_load) && wreg_MEM_i;
    waddr_WB_o   = (pass || wb_load) ? waddr_MEM_i : 5'd0;
    wdata_WB_o   = pass ? alurslt_MEM_i : wb_load ? ext : 32'd0;
  end
  always_ff @(posedge dclk) begin
    if (rst) state <= IDLE;
    else state <= state_n;
  end
  // req drops for one cycle after every ack; the gap cycle re-issues the next byte
  always_ff @(posedge dclk) begin
    if (rst) begin
      cnt         <= '0;
      data        <= '0;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
    end else if (state == IDLE && is_mem) begin
      cnt         <= '0;
      data        <= '0;
      mem_req_o   <= 1'b1;
      mem_we_o    <= is_store;
      mem_addr_o  <= alurslt_MEM_i;
      mem_wdata_o <= storedata_MEM_i[7:0];
    end else if (acked) begin
      cnt       <= cnt + 2'd1;
      mem_req_o <= 1'b0;
      mem_we_o  <= is_store && (cnt != last);
      if (is_load) data[8*cnt +: 8] <= mem_rdata_i;
    end else if (state == XFER && !mem_req_o) begin
      mem_req_o   <= 1'b1;
      mem_we_o    <= is_store;
      mem_addr_o  <= alurslt_MEM_i + {30'd0, cnt};
      mem_wdata_o <= storedata_MEM_i[8*cnt +: 8];
    end
  end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: scoreboard bench with a req/ack byte-memory responder of programmable delay.
module tb_mem_access_unit;
  localparam logic [7:0] NOP = 8'h00, ADD = 8'h01;
  localparam logic [7:0] LB = 8'h20, LH = 8'h21, LW = 8'h22, LBU = 8'h23, LHU = 8'h24;
  localparam logic [7:0] SB = 8'h28, SH = 8'h29, SW = 8'h2A;
  typedef struct {logic we; logic [31:0] addr; logic [7:0] wd;} mx_t;
  typedef struct {logic wreg; logic [4:0] waddr; logic [31:0] wdata;} wb_t;
  logic dclk = 0, rst = 1;
  logic [7:0] aluop = NOP;
  logic wreg = 0;
  logic [4:0] waddr = 0;
  logic [31:0] alu = 0, sdata = 0;
  logic mem_req, mem_we, mem_ack, ack_auto = 0, ack_man = 0;
  logic [31:0] mem_addr;
  logic [7:0] mem_wdata, mem_rdata = 0;
  logic stlreq, wreg_wb;
  logic [4:0] waddr_wb;
  logic [31:0] wdata_wb;
  logic [7:0] mem [logic [31:0]];
  mx_t mq[$];
  wb_t wbq[$];
  int n_chk = 0, n_err = 0, dly = 1;
  assign mem_ack = ack_auto | ack_man;
  always #5 dclk = ~dclk;
  mem_access_unit dut (
    .dclk(dclk), .rst(rst), .aluop_MEM_i(aluop), .wreg_MEM_i(wreg), .waddr_MEM_i(waddr),
    .alurslt_MEM_i(alu), .storedata_MEM_i(sdata), .mem_req_o(mem_req), .mem_we_o(mem_we),
    .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata), .mem_ack_i(mem_ack),
    .stlreq_MEM_o(stlreq), .wreg_WB_o(wreg_wb), .waddr_WB_o(waddr_wb), .wdata_WB_o(wdata_wb)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic logic [7:0] rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 8'h00;
  endfunction
  // byte-memory responder: acks dly cycles after req rises, checks each transfer against mq
  initial begin
    logic prev_req;
    int age;
    mx_t e;
    prev_req = 0;
    age = 0;
    forever begin
      @(posedge dclk);
      #1;
      ack_auto = 0;
      if (mem_req) begin
        age = prev_req ? age + 1 : 0;
        if (age == dly) begin
          ack_auto = 1;
          chk("mq_nonempty", 32'(mq.size() != 0), 1);
          if (mq.size() != 0) begin
            e = mq.pop_front();
            chk("mem_we", 32'(mem_we), 32'(e.we));
            chk("mem_addr", mem_addr, e.addr);
            if (e.we) chk("mem_wdata", 32'(mem_wdata), 32'(e.wd));
          end
          if (mem_we) mem[mem_addr] = mem_wdata;
          else mem_rdata = rd(mem_addr);
        end
      end
      prev_req = mem_req;
    end
  end
  task automatic run_op(input logic [7:0] op, input logic wr, input logic [4:0] wa,
                        input logic [31:0] a, input logic [31:0] sd, input int d);
    int n, cyc, lat;
    logic st;
    logic [31:0] raw, exp_d;
    mx_t m;
    wb_t w, e;
    dly = d;
    aluop = op; wreg = wr; waddr = wa; alu = a; sdata = sd;
    st = op inside {SB, SH, SW};
    n = (op inside {LB, LBU, SB}) ? 1 : (op inside {LH, LHU, SH}) ? 2 : (op inside {LW, SW}) ? 4 : 0;
    raw = 0;
    for (int i = 0; i < n; i++) begin
      m.we = st; m.addr = a + i; m.wd = sd[8*i +: 8];
      mq.push_back(m);
      raw[8*i +: 8] = rd(a + i);
    end
    case (op)
      LB:  exp_d = {{24{raw[7]}}, raw[7:0]};
      LBU: exp_d = {24'd0, raw[7:0]};
      LH:  exp_d = {{16{raw[15]}}, raw[15:0]};
      LHU: exp_d = {16'd0, raw[15:0]};
      LW:  exp_d = raw;
      SB, SH, SW: exp_d = 0;
      default: exp_d = a;
    endcase
    w.wreg = st ? 1'b0 : wr; w.waddr = st ? 5'd0 : wa; w.wdata = exp_d;
    wbq.push_back(w);
    lat = (n == 0) ? 0 : 1 + n * (d + 1) + (n - 1);
    cyc = 0;
    @(negedge dclk);
    while (stlreq && cyc < 80) begin
      cyc++;
      @(negedge dclk);
    end
    chk("stall_cycles", cyc, lat);
    e = wbq.pop_front();
    chk("wreg_wb", 32'(wreg_wb), 32'(e.wreg));
    chk("waddr_wb", 32'(waddr_wb), 32'(e.waddr));
    chk("wdata_wb", wdata_wb, e.wdata);
    chk("mq_drained", mq.size(), 0);
    @(posedge dclk);
    #1;
  endtask
  initial begin
    logic [7:0] ops [9];
    mx_t m;
    int cyc;
    ops = '{ADD, LB, LH, LW, LBU, LHU, SB, SH, SW};
    mem[32'h100] = 8'h78; mem[32'h101] = 8'h56; mem[32'h102] = 8'h34; mem[32'h103] = 8'h12;
    mem[32'h40] = 8'h80; mem[32'h50] = 8'h34; mem[32'h51] = 8'hF2;
    for (int i = 0; i < 16; i++) mem[32'h400 + i] = 8'($urandom);
    repeat (2) @(posedge dclk);
    @(negedge dclk);
    chk("rst_req", 32'(mem_req), 0);
    chk("rst_we", 32'(mem_we), 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", 32'(mem_wdata), 0);
    chk("rst_stlreq", 32'(stlreq), 0);
    @(posedge dclk);
    #1 rst = 0;
    run_op(ADD, 1, 5, 32'h1234, 0, 1);
    run_op(LW, 1, 9, 32'h100, 0, 1);
    run_op(LB, 1, 3, 32'h40, 0, 0);
    run_op(LBU, 1, 4, 32'h40, 0, 2);
    run_op(LH, 1, 6, 32'h50, 0, 1);
    run_op(LHU, 1, 6, 32'h50, 0, 0);
    run_op(SH, 1, 8, 32'h200, 32'hAABBCCDD, 1);
    run_op(LH, 1, 10, 32'h200, 0, 0);
    run_op(SW, 1, 11, 32'hFFFFFFFE, 32'h11223344, 0);
    run_op(LW, 1, 12, 32'hFFFFFFFE, 0, 2);
    run_op(NOP, 0, 0, 32'h0, 0, 1);
    // reset in the gap after the first byte of a word load
    dly = 1;
    aluop = LW; wreg = 1; waddr = 7; alu = 32'h300; sdata = 0;
    m.we = 0; m.addr = 32'h300; m.wd = 0;
    mq.push_back(m);
    cyc = 0;
    do begin
      @(negedge dclk);
      cyc++;
    end while (!mem_ack && cyc < 20);
    chk("rst_ack_seen", 32'(mem_ack), 1);
    @(posedge dclk);
    #1 rst = 1; aluop = NOP; wreg = 0; waddr = 3; alu = 32'h55;
    @(posedge dclk);
    #1 rst = 0;
    @(negedge dclk);
    chk("rst_mid_req", 32'(mem_req), 0);
    chk("rst_mid_stl", 32'(stlreq), 0);
    chk("rst_mid_wdata", wdata_wb, 32'h55);
    ack_man = 1;
    @(posedge dclk);
    #1 ack_man = 0;
    @(negedge dclk);
    chk("late_ack_req", 32'(mem_req), 0);
    chk("late_ack_stl", 32'(stlreq), 0);
    chk("late_ack_mq", mq.size(), 0);
    @(posedge dclk);
    #1;
    run_op(LW, 1, 13, 32'h100, 0, 1);
    for (int k = 0; k < 30; k++)
      run_op(ops[$urandom_range(0, 8)], 1'($urandom), 5'($urandom), 32'h400 + $urandom_range(0, 12),
             $urandom, $urandom_range(0, 2));
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- MEM-stage consumer of the EX/MEM pipeline register outputs.
- Non-memory ops pass straight through to the MEM/WB register with zero latency.
- Loads and stores run as byte-serial transfers on an 8-bit req/ack data-memory port. A stall request to the pipeline staller stays asserted until the transfer completes.
- Sign/zero extension for loads happens here.

Parameters:
- ALUOP_W, 8, width of the aluop bus.
- OP_LB, 8'h20, load byte, sign-extended.
- OP_LH, 8'h21, load half, sign-extended.
- OP_LW, 8'h22, load word.
- OP_LBU, 8'h23, load byte, zero-extended.
- OP_LHU, 8'h24, load half, zero-extended.
- OP_SB, 8'h28, store byte.
- OP_SH, 8'h29, store half.
- OP_SW, 8'h2A, store word.

Ports:
- dclk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- aluop_MEM_i  in  ALUOP_W  operation from EX/MEM.
- wreg_MEM_i  in  1  register write enable from EX/MEM.
- waddr_MEM_i  in  5  destination register.
- alurslt_MEM_i  in  32  ALU result; effective address for memory ops.
- storedata_MEM_i  in  32  store data.
- mem_req_o  out  1  byte transfer request.
- mem_we_o  out  1  1 = write, 0 = read.
- mem_addr_o  out  32  byte address.
- mem_wdata_o  out  8  write byte.
- mem_rdata_i  in  8  read byte, valid when mem_ack_i = 1.
- mem_ack_i  in  1  transfer complete, one-cycle pulse.
- stlreq_MEM_o  out  1  stall request to staller.
- wreg_WB_o  out  1  to MEM/WB.
- waddr_WB_o  out  5  to MEM/WB.
- wdata_WB_o  out  32  to MEM/WB.

Behaviour:
- Clock and reset: one clock (dclk); reset is synchronous and active-high (rst, sampled on posedge dclk).
- Reset state: FSM = IDLE, byte counter = 0, assembled data = 0, mem_req_o = 0, mem_we_o = 0, mem_addr_o = 0, mem_wdata_o = 0. Reset overrides everything, including mid-transfer: an outstanding request is dropped and a late ack is ignored.
- States: IDLE, XFER, DONE.
- IDLE, non-memory op:
  - wreg_WB_o = wreg_MEM_i, waddr_WB_o = waddr_MEM_i, wdata_WB_o = alurslt_MEM_i, combinationally.
  - stlreq_MEM_o = 0.
- IDLE, memory op:
  - stlreq_MEM_o = 1 combinationally in the same cycle.
  - wreg_WB_o = 0, waddr_WB_o = 0, wdata_WB_o = 0.
  - Next edge: go to XFER, counter = 0, byte count N = 1/2/4 for B/H/W.
- XFER:
  - mem_req_o = 1 (registered).
  - mem_addr_o = alurslt_MEM_i + counter (little-endian).
  - Stores: mem_we_o = 1, mem_wdata_o = storedata_MEM_i[8*counter +: 8].
  - On mem_ack_i:
    - Loads capture mem_rdata_i into byte lane [counter].
    - Counter increments.
    - mem_req_o drops for exactly one cycle before the next byte.
    - After byte N-1, go to DONE.
  - stlreq_MEM_o = 1 throughout XFER.
  - Address addition wraps mod 2^32 (0xFFFFFFFF + 1 = 0).
  - Misaligned addresses are legal and handled byte-serially.
- DONE (one cycle):
  - stlreq_MEM_o = 0, mem_req_o = 0.
  - Loads: wreg_WB_o = wreg_MEM_i, waddr_WB_o = waddr_MEM_i, wdata_WB_o = assembled data, extended per op (LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend).
  - Stores: wreg_WB_o = 0, waddr_WB_o = 0, wdata_WB_o = 0.
  - Next edge: unconditionally return to IDLE. The EX/MEM register advances on this same edge, so the completed op is never re-issued.
- Inputs: aluop/addr/data are held stable by the staller while stlreq_MEM_o = 1. The block does not latch them.
- An ack arriving while mem_req_o = 0 is ignored.
- Latency: memory op of N bytes with ack delay d (cycles from req to ack) holds stall for 1 + N·(d+1) + (N-1) cycles.
- A bubble (aluop = NOP, wreg = 0) behaves as a non-memory op.

Test Plan:
- ADD result: aluop = ALU op, wreg = 1, waddr = 5, alurslt = 0x1234 → same cycle wreg_WB_o = 1, waddr_WB_o = 5, wdata_WB_o = 0x1234; stlreq_MEM_o = 0; no mem_req_o.
- LW at 0x100, memory holds bytes 78,56,34,12, ack 1 cycle after each req → four reads at 0x100..0x103; DONE gives wdata_WB_o = 0x12345678; stlreq_MEM_o low only in DONE.
- LB at 0x40 = 0x80 → wdata_WB_o = 0xFFFFFF80. LBU at the same address → wdata_WB_o = 0x00000080. LH of bytes 0x34,0xF2 → wdata_WB_o = 0xFFFFF234.
- SH at 0x200 with storedata = 0xAABBCCDD → writes 0xDD@0x200 and 0xCC@0x201 with mem_we_o = 1; wreg_WB_o = 0 in DONE.
- SW at 0xFFFFFFFE → bytes go to 0xFFFFFFFE, 0xFFFFFFFF, 0x0, 0x1 (address wrap).
- rst asserted in XFER after byte 1 of an LW → next cycle FSM = IDLE, mem_req_o = 0, counter = 0; an ack arriving afterwards has no effect; a following LW completes correctly.
